vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal front porch, sync and back porch in pixels; H_TOTAL = 800.
REQ-003 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical front porch, sync and back porch in lines; V_TOTAL = 525.
REQ-005 clk25  in  1  25 MHz pixel clock; the block's only clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 x  out  10  current horizontal pixel count, 0..H_TOTAL-1.
REQ-008 y  out  10  current line count, 0..V_TOTAL-1.
REQ-009 video_on  out  1  high while x < H_ACTIVE and y < V_ACTIVE.
REQ-010 frame_tick  out  1  one-cycle pulse when x == H_ACTIVE-1 and y == V_ACTIVE-1, i.e. the last visible pixel.
REQ-011 pix_rgb  in  3  pixel colour for the current (x,y), produced combinationally by the overlay logic.
REQ-012 vga_hsync  out  1  horizontal sync to the connector, active low.
REQ-013 vga_vsync  out  1  vertical sync to the connector, active low.
REQ-014 vga_rgb  out  3  registered, blanked pixel colour to the connector.

Function
REQ-015 The horizontal counter SHALL increment by 1 on every clk25 edge and wrap from H_TOTAL-1 to 0.
REQ-016 The vertical counter SHALL increment by 1 only on the cycle the horizontal counter wraps, and SHALL wrap from V_TOTAL-1 to 0 on that same cycle.
REQ-017 x, y, video_on and frame_tick SHALL be driven directly from the counter registers with zero added latency.
REQ-018 Overlay modules SHALL return pix_rgb for (x,y) within the same cycle.
REQ-019 vga_rgb SHALL register pix_rgb when video_on is 1, and SHALL register 3'b000 otherwise, giving one cycle of latency.
REQ-020 vga_hsync SHALL register 0 when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751), and 1 otherwise.
REQ-021 vga_vsync SHALL register 0 when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491), and 1 otherwise.
REQ-022 The registered vga_hsync, vga_vsync and vga_rgb SHALL all carry the same one-cycle delay, so they stay mutually aligned.
REQ-023 frame_tick SHALL assert exactly once per frame, i.e. once every 420000 cycles.
REQ-024 All counter comparisons SHALL be unsigned 10-bit; no counter value above its TOTAL-1 SHALL ever occur.

Reset
REQ-025 While reset is high at a clk25 edge, the counters SHALL load 0, vga_hsync and vga_vsync SHALL load 1, and vga_rgb SHALL load 3'b000.
REQ-026 With counters at 0, x = 0, y = 0, video_on = 1 and frame_tick = 0 SHALL hold during reset.
REQ-027 A reset asserted mid-frame SHALL abort the frame with no frame_tick in the reset cycle.
REQ-028 After reset is released, counting SHALL restart from (0,0) on the first edge.
REQ-029 pix_rgb SHALL be ignored while reset is high.

Structure
REQ-030 The timing constants (active, porch, sync and total for each axis) and the sync polarity SHALL live in shared package vga_pkg, so overlay blocks use the same screen bounds.
REQ-031 The 3-bit RGB colour type SHALL live in vga_pkg.
REQ-032 The block SHALL be a single module with no sub-module.
REQ-033 The counters, decode and output register SHALL be separate always blocks.

Verification
REQ-034 Release reset, then run 800 cycles -> x counts 0..799 and returns to 0; y increments to 1 on the cycle x wraps.
REQ-035 Free-run 2 frames -> vga_hsync is low for exactly 96 cycles per line, with its first low sample one cycle after x == 656; vga_vsync is low for exactly 1600 cycles per frame, starting one cycle after (x,y) = (0,490).
REQ-036 Drive pix_rgb = 3'b111 constantly -> vga_rgb = 3'b111 one cycle after each x in 0..639 with y < 480, and 3'b000 one cycle after x = 640 and throughout lines 480..524.
REQ-037 Count frame_tick over 3 frames -> exactly 3 pulses, spaced 420000 cycles apart, each coinciding with (x,y) = (639,479).
REQ-038 Assert reset for 1 cycle at (x,y) = (700,300) -> next cycle x = 0, y = 0, vga_hsync = 1, vga_vsync = 1, vga_rgb = 000.
REQ-039 Connect a single-pixel overlay lit at (x,y) = (20,5) -> vga_rgb is 111 for exactly one cycle per frame, one cycle after (20,5).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing definitions.
//
// Holds the 640x480@60 timing constants for both axes, the sync polarity and
// the RGB colour type so that the timing generator and every overlay block
// agree on the same screen bounds.
package vga_pkg;

    // Horizontal timing, in pixels
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    // Vertical timing, in lines
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Level driven on hsync/vsync during the sync pulse (negative polarity)
    localparam logic VGA_SYNC_ACTIVE = 1'b0;

    // 3-bit colour, one bit each for R, G, B
    typedef logic [2:0] rgb_t;

    localparam rgb_t RGB_BLACK = 3'b000;

endpackage

// File: rtl/vga_timing_gen.sv
// VGA timing generator.
//
// Free-running horizontal/vertical counters that produce the raster position
// for overlay logic and the registered, mutually aligned sync and colour
// outputs for the connector.
//
// Ports
//   clk25      in   1   pixel clock
//   reset      in   1   synchronous, active-high reset
//   pix_rgb    in   3   colour for the current (x,y) from overlay logic
//   x          out  10  horizontal pixel count, 0..H_TOTAL-1
//   y          out  10  line count, 0..V_TOTAL-1
//   video_on   out  1   current (x,y) lies in the visible area
//   frame_tick out  1   one-cycle pulse on the last visible pixel
//   vga_hsync  out  1   registered horizontal sync, active low
//   vga_vsync  out  1   registered vertical sync, active low
//   vga_rgb    out  3   registered, blanked colour
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic       clk25,
    input  logic       reset,
    input  logic [2:0] pix_rgb,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       frame_tick,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic [2:0] vga_rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // All bounds are 10-bit unsigned so every compare is against the counter width
    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS_END    = 10'(V_ACTIVE);
    localparam logic [9:0] H_VIS_LAST   = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_VIS_LAST   = 10'(V_ACTIVE - 1);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_wrap;
    logic       visible;
    logic       h_in_sync;
    logic       v_in_sync;

    // Raster counters: y advances only on the cycle x wraps, and wraps itself
    // on that same cycle at the end of the frame.
    always_ff @(posedge clk25) begin : counters
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    always_comb begin : decode
        // NOTE: every signal gets a default first so no path can infer a latch.
        h_wrap    = 1'b0;
        visible   = 1'b0;
        h_in_sync = 1'b0;
        v_in_sync = 1'b0;

        h_wrap    = (h_cnt == H_LAST);
        visible   = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
        h_in_sync = (h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END);
        v_in_sync = (v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END);
    end

    // Connector outputs share a single register stage so sync and colour
    // remain aligned with each other, one pixel behind (x,y).
    always_ff @(posedge clk25) begin : out_reg
        if (reset) begin
            vga_hsync <= ~VGA_SYNC_ACTIVE;
            vga_vsync <= ~VGA_SYNC_ACTIVE;
            vga_rgb   <= RGB_BLACK;
        end else begin
            vga_hsync <= h_in_sync ? VGA_SYNC_ACTIVE : ~VGA_SYNC_ACTIVE;
            vga_vsync <= v_in_sync ? VGA_SYNC_ACTIVE : ~VGA_SYNC_ACTIVE;
            vga_rgb   <= visible ? pix_rgb : RGB_BLACK;
        end
    end

    assign x        = h_cnt;
    assign y        = v_cnt;
    assign video_on = visible;
    // Gated by reset so a frame aborted on its last visible pixel does not tick
    assign frame_tick = (h_cnt == H_VIS_LAST) && (v_cnt == V_VIS_LAST) && !reset;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen.
// dut runs the default 640x480 timing for line-level behaviour; dut_s runs a
// reduced 16x8 screen (25x15 total) so whole frames fit in a short run.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int D_HT = 800;
    localparam int D_VT = 525;
    localparam int S_HT = 25;   // 16 + 2 + 4 + 3
    localparam int S_VT = 15;   // 8 + 2 + 2 + 3
    localparam int S_FRAME = S_HT * S_VT;   // 375

    logic       clk25 = 1'b0;
    logic       reset;
    logic [2:0] const_rgb;
    logic       ovl_en;
    logic [2:0] pix_d, pix_s;
    logic [9:0] x_d, y_d, x_s, y_s;
    logic       von_d, von_s, ft_d, ft_s, hs_d, hs_s, vs_d, vs_s;
    logic [2:0] rgb_d, rgb_s;

    int checks = 0;
    int errors = 0;

    // Bench model of each raster position (current and pre-edge)
    int d_x = 0, d_y = 0, d_px = 0, d_py = 0;
    int s_x = 0, s_y = 0, s_px = 0, s_py = 0;

    always #20 clk25 = ~clk25;

    // Single-pixel overlays, or a constant colour when disabled
    assign pix_d = ovl_en ? ((x_d == 10'd20 && y_d == 10'd5) ? 3'b111 : 3'b000) : const_rgb;
    assign pix_s = ovl_en ? ((x_s == 10'd5  && y_s == 10'd3) ? 3'b111 : 3'b000) : const_rgb;

    vga_timing_gen dut (
        .clk25(clk25), .reset(reset), .pix_rgb(pix_d),
        .x(x_d), .y(y_d), .video_on(von_d), .frame_tick(ft_d),
        .vga_hsync(hs_d), .vga_vsync(vs_d), .vga_rgb(rgb_d)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut_s (
        .clk25(clk25), .reset(reset), .pix_rgb(pix_s),
        .x(x_s), .y(y_s), .video_on(von_s), .frame_tick(ft_s),
        .vga_hsync(hs_s), .vga_vsync(vs_s), .vga_rgb(rgb_s)
    );

    // One clock edge; models advance, outputs are sampled 1 ns after the edge
    task automatic tick();
        d_px = d_x; d_py = d_y; s_px = s_x; s_py = s_y;
        @(posedge clk25);
        if (reset) begin
            d_x = 0; d_y = 0; s_x = 0; s_y = 0;
        end else begin
            if (d_x == D_HT - 1) begin d_x = 0; d_y = (d_y == D_VT - 1) ? 0 : d_y + 1; end
            else d_x = d_x + 1;
            if (s_x == S_HT - 1) begin s_x = 0; s_y = (s_y == S_VT - 1) ? 0 : s_y + 1; end
            else s_x = s_x + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; const_rgb = 3'b111; ovl_en = 1'b0;
        repeat (3) tick();
        checks++;
        if (x_d !== 10'd0 || y_d !== 10'd0 || von_d !== 1'b1 || ft_d !== 1'b0) begin
            errors++;
            $display("FAIL reset_counters: x=%0d y=%0d video_on=%b frame_tick=%b, expected 0 0 1 0",
                     x_d, y_d, von_d, ft_d);
        end
        checks++;
        if (hs_d !== 1'b1 || vs_d !== 1'b1 || rgb_d !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: hsync=%b vsync=%b rgb=%b, expected 1 1 000", hs_d, vs_d, rgb_d);
        end
        checks++;
        if (x_s !== 10'd0 || y_s !== 10'd0 || rgb_s !== 3'b000) begin
            errors++;
            $display("FAIL reset_small: x=%0d y=%0d rgb=%b, expected 0 0 000", x_s, y_s, rgb_s);
        end
        reset = 1'b0;
    endtask

    // One full line: x runs 0..799, then wraps with y stepping to 1
    task automatic test_h_count();
        int bad = 0;
        for (int i = 0; i < D_HT; i++) begin
            checks++;
            if (x_d !== 10'(i) || y_d !== 10'd0) begin
                errors++;
                if (bad++ < 5) $display("FAIL h_count: x=%0d y=%0d, expected %0d 0", x_d, y_d, i);
            end
            tick();
        end
        checks++;
        if (x_d !== 10'd0 || y_d !== 10'd1) begin
            errors++;
            $display("FAIL h_wrap: x=%0d y=%0d, expected 0 1", x_d, y_d);
        end
    endtask

    // Two lines with constant white: hsync and blanked colour per pixel
    task automatic test_line_outputs();
        int hs_low = 0;
        int bad = 0;
        logic exp_hs;
        logic [2:0] exp_rgb;
        const_rgb = 3'b111;
        for (int n = 0; n < 2 * D_HT; n++) begin
            tick();
            exp_hs  = !(d_px >= 656 && d_px < 752);
            exp_rgb = (d_px < 640 && d_py < 480) ? 3'b111 : 3'b000;
            if (hs_d === 1'b0) hs_low++;
            checks++;
            if (hs_d !== exp_hs || rgb_d !== exp_rgb || vs_d !== 1'b1 ||
                x_d !== 10'(d_x) || von_d !== (d_x < 640) || ft_d !== 1'b0) begin
                errors++;
                if (bad++ < 5)
                    $display("FAIL line_outputs: prev_x=%0d hsync=%b rgb=%b vsync=%b x=%0d von=%b, expected %b %b 1 %0d %b",
                             d_px, hs_d, rgb_d, vs_d, x_d, von_d, exp_hs, exp_rgb, d_x, (d_x < 640));
            end
        end
        checks++;
        if (hs_low != 2 * 96) begin
            errors++;
            $display("FAIL hsync_width: low cycles=%0d, expected %0d", hs_low, 2 * 96);
        end
    endtask

    // Overlay lit at (20,5): exactly one white cycle, right after that pixel
    task automatic test_overlay_default();
        int lit = 0;
        int bad = 0;
        int n = 0;
        logic [2:0] exp_rgb;
        ovl_en = 1'b1;
        while (!(d_x == 0 && d_y == 8) && n < 10000) begin
            tick();
            n++;
            exp_rgb = (d_px == 20 && d_py == 5) ? 3'b111 : 3'b000;
            if (rgb_d === 3'b111) lit++;
            checks++;
            if (rgb_d !== exp_rgb) begin
                errors++;
                if (bad++ < 5) $display("FAIL overlay_default: prev=(%0d,%0d) rgb=%b, expected %b", d_px, d_py, rgb_d, exp_rgb);
            end
        end
        checks++;
        if (lit != 1 || n >= 10000) begin
            errors++;
            $display("FAIL overlay_default_count: lit=%0d cycles=%0d, expected 1 lit", lit, n);
        end
        ovl_en = 1'b0;
    endtask

    // Reset pulse at x=700 (inside hsync): everything returns to idle next cycle
    task automatic test_mid_reset();
        int n = 0;
        while (d_x != 700 && n < 1000) begin tick(); n++; end
        checks++;
        if (n >= 1000 || x_d !== 10'd700) begin
            errors++;
            $display("FAIL mid_reset_reach: x=%0d after %0d cycles, expected 700", x_d, n);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (x_d !== 10'd0 || y_d !== 10'd0 || hs_d !== 1'b1 || vs_d !== 1'b1 || rgb_d !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset: x=%0d y=%0d hsync=%b vsync=%b rgb=%b, expected 0 0 1 1 000",
                     x_d, y_d, hs_d, vs_d, rgb_d);
        end
    endtask

    // Three small frames: three ticks, 375 cycles apart, at (15,7)
    task automatic test_frame_tick();
        int pulses = 0;
        int first = -1;
        int last = -1;
        int bad = 0;
        for (int i = 0; i < 3 * S_FRAME; i++) begin
            checks++;
            if (ft_s !== (s_x == 15 && s_y == 7)) begin
                errors++;
                if (bad++ < 5) $display("FAIL frame_tick: at (%0d,%0d) tick=%b", x_s, y_s, ft_s);
            end
            if (ft_s === 1'b1) begin
                if (pulses == 0) first = i;
                else begin
                    checks++;
                    if (i - last != S_FRAME) begin
                        errors++;
                        $display("FAIL frame_tick_spacing: %0d cycles, expected %0d", i - last, S_FRAME);
                    end
                end
                last = i;
                pulses++;
            end
            tick();
        end
        checks++;
        if (pulses != 3 || first != 7 * S_HT + 15) begin
            errors++;
            $display("FAIL frame_tick_count: pulses=%0d first=%0d, expected 3 at %0d", pulses, first, 7 * S_HT + 15);
        end
    endtask

    // Two small frames: per-cycle sync/colour and total sync widths
    task automatic test_small_sync();
        int vs_low = 0;
        int hs_low = 0;
        int bad = 0;
        logic exp_hs, exp_vs;
        logic [2:0] exp_rgb;
        const_rgb = 3'b111;
        for (int n = 0; n < 2 * S_FRAME; n++) begin
            tick();
            exp_hs  = !(s_px >= 18 && s_px < 22);
            exp_vs  = !(s_py >= 10 && s_py < 12);
            exp_rgb = (s_px < 16 && s_py < 8) ? 3'b111 : 3'b000;
            if (vs_s === 1'b0) vs_low++;
            if (hs_s === 1'b0) hs_low++;
            checks++;
            if (hs_s !== exp_hs || vs_s !== exp_vs || rgb_s !== exp_rgb) begin
                errors++;
                if (bad++ < 5)
                    $display("FAIL small_sync: prev=(%0d,%0d) hs=%b vs=%b rgb=%b, expected %b %b %b",
                             s_px, s_py, hs_s, vs_s, rgb_s, exp_hs, exp_vs, exp_rgb);
            end
        end
        checks++;
        if (vs_low != 2 * 2 * S_HT || hs_low != 2 * S_VT * 4) begin
            errors++;
            $display("FAIL small_sync_width: vs_low=%0d hs_low=%0d, expected %0d %0d",
                     vs_low, hs_low, 2 * 2 * S_HT, 2 * S_VT * 4);
        end
    endtask

    // Overlay at (5,3) on the small screen: once per frame
    task automatic test_overlay_small();
        int lit = 0;
        int bad = 0;
        logic [2:0] exp_rgb;
        ovl_en = 1'b1;
        for (int n = 0; n < 2 * S_FRAME; n++) begin
            tick();
            exp_rgb = (s_px == 5 && s_py == 3) ? 3'b111 : 3'b000;
            if (rgb_s === 3'b111) lit++;
            checks++;
            if (rgb_s !== exp_rgb) begin
                errors++;
                if (bad++ < 5) $display("FAIL overlay_small: prev=(%0d,%0d) rgb=%b, expected %b", s_px, s_py, rgb_s, exp_rgb);
            end
        end
        checks++;
        if (lit != 2) begin
            errors++;
            $display("FAIL overlay_small_count: lit=%0d, expected 2", lit);
        end
        ovl_en = 1'b0;
    endtask

    // Reset landing on the last visible pixel suppresses the tick; counting restarts
    task automatic test_reset_on_tick();
        int n = 0;
        while (!(s_x == 15 && s_y == 7) && n < 2 * S_FRAME) begin tick(); n++; end
        checks++;
        if (ft_s !== 1'b1) begin
            errors++;
            $display("FAIL tick_before_reset: tick=%b at (%0d,%0d), expected 1 at (15,7)", ft_s, x_s, y_s);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (ft_s !== 1'b0) begin
            errors++;
            $display("FAIL tick_in_reset: tick=%b, expected 0", ft_s);
        end
        tick();
        reset = 1'b0;
        checks++;
        if (x_s !== 10'd0 || y_s !== 10'd0 || hs_s !== 1'b1 || vs_s !== 1'b1 || rgb_s !== 3'b000) begin
            errors++;
            $display("FAIL small_reset: x=%0d y=%0d hs=%b vs=%b rgb=%b, expected 0 0 1 1 000",
                     x_s, y_s, hs_s, vs_s, rgb_s);
        end
        tick();
        checks++;
        if (x_s !== 10'd1 || y_s !== 10'd0 || rgb_s !== 3'b111) begin
            errors++;
            $display("FAIL restart: x=%0d y=%0d rgb=%b, expected 1 0 111", x_s, y_s, rgb_s);
        end
    endtask

    initial begin
        reset = 1'b1;
        const_rgb = 3'b000;
        ovl_en = 1'b0;
        test_reset();
        test_h_count();
        test_line_outputs();
        test_overlay_default();
        test_mid_reset();
        test_frame_tick();
        test_small_sync();
        test_overlay_small();
        test_reset_on_tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
